// File: rtl/vpd_store_responder.sv
// VPD word store answering the cfg_vpd_* request channel with a one-cycle done pulse.
// Optional macro VPD_STORE_WRITE_EN: writable RAM with a post-reset zeroing sweep; otherwise a ROM.
module vpd_store_responder #(
  parameter int    DEPTH_LOG2 = 8,
  parameter string INIT_FILE  = ""
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [14:0] cfg_vpd_addr,
  input  logic        cfg_vpd_wren,
  input  logic [31:0] cfg_vpd_wdata,
  input  logic        cfg_vpd_rden,
  output logic [31:0] vpd_cfg_rdata,
  output logic        vpd_cfg_done,
  output logic        vpd_err_unimplemented_addr,
  output logic        vpd_ready
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [2:0] {CLEAR, IDLE, RD_ACC, RESP, WAIT_REL} state_t;

`ifdef VPD_STORE_WRITE_EN
  localparam bit     WRITABLE    = 1'b1;
  localparam state_t RESET_STATE = CLEAR;
`else
  localparam bit     WRITABLE    = 1'b0;
  localparam state_t RESET_STATE = IDLE;
`endif

  state_t                state;
  logic [DEPTH_LOG2-1:0] clr_cnt;
  logic [31:0]           mem [DEPTH];
  logic [31:0]           mem_q;

  logic [12:0]           word_idx;
  logic [DEPTH_LOG2-1:0] mem_idx;
  logic                  in_range;
  logic                  req_err;
  logic                  wr_ok;

  assign word_idx  = cfg_vpd_addr[14:2];
  assign mem_idx   = word_idx[DEPTH_LOG2-1:0];
  assign in_range  = {1'b0, word_idx} < 14'(DEPTH);
  assign req_err   = (cfg_vpd_rden & cfg_vpd_wren) | ~in_range | (cfg_vpd_wren & ~WRITABLE);
  assign wr_ok     = (state == IDLE) & cfg_vpd_wren & ~req_err & ~reset;
  assign vpd_ready = (state == IDLE);

`ifdef VPD_STORE_WRITE_EN
  logic unused_ok;
  assign unused_ok = ^{cfg_vpd_addr[1:0], wr_ok};

  always_ff @(posedge clock) begin
    // NOTE: the store array has no reset branch; the CLEAR sweep zeroes it one word per cycle.
    if (state == CLEAR && !reset) mem[clr_cnt] <= '0;
    else if (wr_ok)               mem[mem_idx] <= cfg_vpd_wdata;
    mem_q <= mem[mem_idx];
  end
`else
  logic unused_ok;
  assign unused_ok = ^{cfg_vpd_addr[1:0], cfg_vpd_wdata, wr_ok};

  // ROM image is fixed at elaboration as all zeros.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  always_ff @(posedge clock) begin
    mem_q <= mem[mem_idx];
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state                      <= RESET_STATE;
      clr_cnt                    <= '0;
      vpd_cfg_rdata              <= '0;
      vpd_cfg_done               <= 1'b0;
      vpd_err_unimplemented_addr <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low every cycle so they can only ever be one cycle wide.
      vpd_cfg_done               <= 1'b0;
      vpd_err_unimplemented_addr <= 1'b0;
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == '1) state <= IDLE;
        end
        IDLE: begin
          if (cfg_vpd_rden || cfg_vpd_wren) begin
            if (req_err) begin
              state                      <= RESP;
              vpd_cfg_done               <= 1'b1;
              vpd_err_unimplemented_addr <= 1'b1;
              if (cfg_vpd_rden) vpd_cfg_rdata <= '0;
            end else if (cfg_vpd_wren) begin
              state        <= RESP;
              vpd_cfg_done <= 1'b1;
            end else begin
              state <= RD_ACC;
            end
          end
        end
        RD_ACC: begin
          vpd_cfg_rdata <= mem_q;
          vpd_cfg_done  <= 1'b1;
          state         <= RESP;
        end
        RESP:     state <= WAIT_REL;
        WAIT_REL: if (!cfg_vpd_rden && !cfg_vpd_wren) state <= IDLE;
        default:  state <= RESET_STATE;
      endcase
    end
  end

endmodule

// File: tb/tb_vpd_store_responder.sv
// Randomized self-checking bench for vpd_store_responder against a transaction-level store model.
module tb_vpd_store_responder;

  localparam int DL    = 8;
  localparam int DEPTH = 1 << DL;

`ifdef VPD_STORE_WRITE_EN
  localparam bit WEN = 1'b1;
`else
  localparam bit WEN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [14:0] cfg_vpd_addr = '0;
  logic        cfg_vpd_wren = 1'b0;
  logic [31:0] cfg_vpd_wdata = '0;
  logic        cfg_vpd_rden = 1'b0;
  logic [31:0] vpd_cfg_rdata;
  logic        vpd_cfg_done;
  logic        vpd_err_unimplemented_addr;
  logic        vpd_ready;

  int errors = 0;
  int checks = 0;

  logic [31:0] ref_mem [DEPTH];
  logic [31:0] ref_rdata;

  vpd_store_responder #(.DEPTH_LOG2(DL), .INIT_FILE("")) dut (
    .clock                      (clock),
    .reset                      (reset),
    .cfg_vpd_addr               (cfg_vpd_addr),
    .cfg_vpd_wren               (cfg_vpd_wren),
    .cfg_vpd_wdata              (cfg_vpd_wdata),
    .cfg_vpd_rden               (cfg_vpd_rden),
    .vpd_cfg_rdata              (vpd_cfg_rdata),
    .vpd_cfg_done               (vpd_cfg_done),
    .vpd_err_unimplemented_addr (vpd_err_unimplemented_addr),
    .vpd_ready                  (vpd_ready)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!vpd_ready && n < 1000) begin
      @(negedge clock);
      n++;
    end
    if (!vpd_ready) check({tag, "_ready_timeout"}, 32'(vpd_ready), 32'd1);
  endtask

  // Reset, check reset outputs, then measure how long ready stays low.
  task automatic do_reset(input string tag);
    int n;
    reset        = 1'b1;
    cfg_vpd_rden = 1'b0;
    cfg_vpd_wren = 1'b0;
    repeat (2) @(negedge clock);
    check({tag, "_rst_done"},  32'(vpd_cfg_done), 32'd0);
    check({tag, "_rst_err"},   32'(vpd_err_unimplemented_addr), 32'd0);
    check({tag, "_rst_rdata"}, vpd_cfg_rdata, 32'd0);
    reset = 1'b0;
    n = 0;
    while (!vpd_ready && n < 1000) begin
      n++;
      @(negedge clock);
    end
    check({tag, "_clear_cycles"}, 32'(n), WEN ? 32'(DEPTH) : 32'd0);
    if (WEN) for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    ref_rdata = '0;
  endtask

  // One request: model predicts latency, error flag and read data from the store rules.
  task automatic do_req(input bit rd, input bit wr, input logic [14:0] a,
                        input logic [31:0] d, input int hold, input string tag);
    int          idx, exp_lat, lat, ndone, nerr;
    bit          e;
    logic [31:0] got_rd;
    idx = int'(a[14:2]);
    e   = (rd && wr) || (idx >= DEPTH) || (wr && !WEN);
    if (e) begin
      exp_lat = 1;
      if (rd) ref_rdata = '0;
    end else if (wr) begin
      exp_lat = 1;
      ref_mem[idx] = d;
    end else begin
      exp_lat = 2;
      ref_rdata = ref_mem[idx];
    end

    wait_ready(tag);
    cfg_vpd_rden  = rd;
    cfg_vpd_wren  = wr;
    cfg_vpd_addr  = a;
    cfg_vpd_wdata = d;
    lat = 0; ndone = 0; nerr = 0; got_rd = '0;
    for (int k = 1; k <= hold; k++) begin
      @(negedge clock);
      if (vpd_cfg_done) begin
        ndone++;
        if (lat == 0) begin
          lat    = k;
          got_rd = vpd_cfg_rdata;
        end
      end
      if (vpd_err_unimplemented_addr) nerr++;
    end
    cfg_vpd_rden = 1'b0;
    cfg_vpd_wren = 1'b0;

    check({tag, "_done_count"}, 32'(ndone), 32'd1);
    check({tag, "_latency"},    32'(lat),   32'(exp_lat));
    check({tag, "_err"},        32'(nerr),  32'(e));
    check({tag, "_rdata"},      got_rd,     ref_rdata);
    @(negedge clock);
    check({tag, "_ready_after"}, 32'(vpd_ready), 32'd1);
    check({tag, "_rdata_held"},  vpd_cfg_rdata, ref_rdata);
  endtask

  function automatic logic [14:0] in_addr(input int idx);
    logic [1:0] lo;
    lo = 2'($urandom_range(0, 3));
    return {13'(idx), lo};
  endfunction

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    ref_rdata = '0;

    do_reset("init");

    do_req(1'b1, 1'b0, 15'h0010, 32'h0,        3,  "rd_0010");
    do_req(1'b0, 1'b1, 15'h0044, 32'hA5A55A5A, 3,  "wr_0044");
    do_req(1'b1, 1'b0, 15'h0044, 32'h0,        3,  "rd_0044");
    do_req(1'b1, 1'b0, 15'h0045, 32'h0,        4,  "rd_0045");
    do_req(1'b1, 1'b0, 15'h0400, 32'h0,        3,  "rd_oor");
    do_req(1'b1, 1'b1, 15'h0008, 32'h12345678, 3,  "both_0008");
    do_req(1'b1, 1'b0, 15'h0008, 32'h0,        3,  "rd_0008");
    do_req(1'b0, 1'b1, 15'h7FFC, 32'hDEADBEEF, 3,  "wr_oor_top");
    do_req(1'b0, 1'b1, 15'h03FC, 32'h0BADF00D, 3,  "wr_last");
    do_req(1'b1, 1'b0, 15'h03FF, 32'h0,        3,  "rd_last");
    do_req(1'b1, 1'b0, 15'h0044, 32'h0,        20, "hold20");
    do_req(1'b1, 1'b0, 15'h0044, 32'h0,        3,  "rearm");

    for (int i = 0; i < 60; i++) begin
      int          sel, idx;
      logic [31:0] d;
      sel = $urandom_range(0, 9);
      idx = $urandom_range(0, 15);
      d   = $urandom;
      case (sel)
        0, 1, 2, 3: do_req(1'b1, 1'b0, in_addr(idx), d, $urandom_range(3, 6), "rnd_rd");
        4, 5, 6:    do_req(1'b0, 1'b1, in_addr(idx), d, $urandom_range(3, 6), "rnd_wr");
        7:          do_req(1'b1, 1'b0, in_addr($urandom_range(DEPTH, 8191)), d, 3, "rnd_rd_oor");
        8:          do_req(1'b1, 1'b1, in_addr(idx), d, 3, "rnd_both");
        default:    do_req(1'b0, 1'b1, in_addr($urandom_range(DEPTH, 8191)), d, 3, "rnd_wr_oor");
      endcase
    end

    // Make rdata nonzero where possible, then reset while the read sits in RD_ACC.
    do_req(1'b0, 1'b1, 15'h0044, 32'hCAFEF00D, 3, "pre_abort_wr");
    do_req(1'b1, 1'b0, 15'h0044, 32'h0,        3, "pre_abort_rd");
    wait_ready("abort");
    cfg_vpd_rden = 1'b1;
    cfg_vpd_addr = 15'h0044;
    @(negedge clock);
    check("abort_no_done_racc", 32'(vpd_cfg_done), 32'd0);
    reset        = 1'b1;
    cfg_vpd_rden = 1'b0;
    @(negedge clock);
    check("abort_done",  32'(vpd_cfg_done), 32'd0);
    check("abort_err",   32'(vpd_err_unimplemented_addr), 32'd0);
    check("abort_rdata", vpd_cfg_rdata, 32'd0);
    check("abort_ready", 32'(vpd_ready), WEN ? 32'd0 : 32'd1);
    do_reset("post_abort");

    do_req(1'b0, 1'b1, 15'h0000, 32'h5A5A1234, 3, "wr_0000");
    do_req(1'b1, 1'b0, 15'h0000, 32'h0,        3, "rd_0000");
    do_req(1'b1, 1'b0, 15'h0044, 32'h0,        3, "rd_0044_post");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound so a stuck DUT still reaches the summary.
  initial begin
    #2000000;
    errors++;
    $display("FAIL global_timeout: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
